// File: rtl/detect_event_counter.sv
// Event counter and valid/ready snapshot port for the serial pattern detector's 2-bit code.
// Build option: DETECT_CNT_SATURATE_EN makes the counters saturate instead of wrapping.
module detect_event_counter #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned A_THRESH    = 4,
    parameter int unsigned CLR_ON_SNAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       y,
    input  logic             clr,
    input  logic             snap_req,
    input  logic             snap_ready,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_a,
    output logic [CNT_W-1:0] snap_b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             ovf,
    output logic             alarm,
    output logic             illegal
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(A_THRESH);

    logic [0:0]       state, state_next;
    logic             capture, restart;
    logic             inc_a, inc_b, bad_code;
    logic [CNT_W-1:0] cnt_a_next, cnt_b_next;
    logic             ovf_next, alarm_next, illegal_next;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef DETECT_CNT_SATURATE_EN
        return (v == CNT_MAX) ? v : v + 1'b1;
`else
        return v + 1'b1;
`endif
    endfunction

    // Snapshot FSM next state; capture happens on the IDLE->HOLD edge
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (snap_req) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (snap_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Live counters and sticky flags; clr beats restart beats increment
    always_comb begin
        inc_a        = en && (y == 2'b01);
        inc_b        = en && (y == 2'b11);
        bad_code     = en && (y == 2'b10);
        restart      = capture && (CLR_ON_SNAP != 0);
        cnt_a_next   = cnt_a;
        cnt_b_next   = cnt_b;
        ovf_next     = ovf;
        illegal_next = illegal || bad_code;
        if (clr) begin
            cnt_a_next   = '0;
            cnt_b_next   = '0;
            ovf_next     = 1'b0;
            illegal_next = 1'b0;
        end else if (restart) begin
            cnt_a_next = CNT_W'(inc_a);
            cnt_b_next = CNT_W'(inc_b);
        end else begin
            if (inc_a) cnt_a_next = bump(cnt_a);
            if (inc_b) cnt_b_next = bump(cnt_b);
            if ((inc_a && cnt_a == CNT_MAX) || (inc_b && cnt_b == CNT_MAX)) ovf_next = 1'b1;
        end
        alarm_next = clr ? 1'b0 : (alarm || (cnt_a_next >= THRESH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            snap_valid <= 1'b0;
            snap_a     <= '0;
            snap_b     <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            ovf        <= 1'b0;
            alarm      <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_next;
            snap_valid <= (state_next == HOLD);
            if (capture) begin
                snap_a <= cnt_a;
                snap_b <= cnt_b;
            end
            cnt_a      <= cnt_a_next;
            cnt_b      <= cnt_b_next;
            ovf        <= ovf_next;
            alarm      <= alarm_next;
            illegal    <= illegal_next;
        end
    end

endmodule

// File: tb/tb_detect_event_counter.sv
// Directed bench for detect_event_counter: an 8-bit clear-on-snap instance plus a 4-bit one for overflow.
module tb_detect_event_counter;

    logic       clk = 1'b0;
    logic       rst, en, clr, snap_req, snap_ready;
    logic [1:0] y;

    logic       snap_valid, ovf, alarm, illegal;
    logic [7:0] snap_a, snap_b, cnt_a, cnt_b;

    logic       s_valid4, ovf4, alarm4, illegal4;
    logic [3:0] snap_a4, snap_b4, cnt_a4, cnt_b4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    detect_event_counter #(.CNT_W(8), .A_THRESH(4), .CLR_ON_SNAP(1)) dut (
        .clk(clk), .rst(rst), .en(en), .y(y), .clr(clr),
        .snap_req(snap_req), .snap_ready(snap_ready), .snap_valid(snap_valid),
        .snap_a(snap_a), .snap_b(snap_b), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .ovf(ovf), .alarm(alarm), .illegal(illegal)
    );

    detect_event_counter #(.CNT_W(4), .A_THRESH(4), .CLR_ON_SNAP(0)) dut4 (
        .clk(clk), .rst(rst), .en(en), .y(y), .clr(clr),
        .snap_req(snap_req), .snap_ready(snap_ready), .snap_valid(s_valid4),
        .snap_a(snap_a4), .snap_b(snap_b4), .cnt_a(cnt_a4), .cnt_b(cnt_b4),
        .ovf(ovf4), .alarm(alarm4), .illegal(illegal4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; y = 2'b01; clr = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;

        // Reset held with activity on y
        step(); step();
        check("rst_cnt_a", cnt_a, 0);
        check("rst_cnt_b", cnt_b, 0);
        check("rst_valid", snap_valid, 0);
        check("rst_snap_a", snap_a, 0);
        check("rst_snap_b", snap_b, 0);
        check("rst_flags", {ovf, alarm, illegal}, 0);
        rst = 1'b1; y = 2'b00;
        step();
        check("post_rst_cnt_a", cnt_a, 0);
        check("post_rst_valid", snap_valid, 0);

        // Count pattern A with alarm at 4, then pattern B
        y = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("cnt_a_ramp", cnt_a, i);
            check("alarm_ramp", alarm, (i >= 4) ? 1 : 0);
        end
        y = 2'b11;
        repeat (3) step();
        check("cnt_a_5", cnt_a, 5);
        check("cnt_b_3", cnt_b, 3);

        // en = 0 ignores every code
        en = 1'b0;
        y = 2'b01; repeat (3) step();
        y = 2'b11; repeat (2) step();
        y = 2'b10; step();
        check("en0_cnt_a", cnt_a, 5);
        check("en0_cnt_b", cnt_b, 3);
        check("en0_illegal", illegal, 0);
        en = 1'b1;

        // Snapshot with coincident A event
        y = 2'b01; snap_req = 1'b1;
        step();
        check("snap_valid_set", snap_valid, 1);
        check("snap_a_5", snap_a, 5);
        check("snap_b_3", snap_b, 3);
        check("restart_cnt_a", cnt_a, 1);
        check("restart_cnt_b", cnt_b, 0);

        // Hold with ready low; repeated requests ignored
        y = 2'b11;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("hold_valid", snap_valid, 1);
            check("hold_snap_a", snap_a, 5);
            check("hold_snap_b", snap_b, 3);
            check("hold_cnt_b", cnt_b, i);
        end
        snap_req = 1'b0; y = 2'b00; snap_ready = 1'b1;
        step();
        check("accept_valid", snap_valid, 0);
        check("accept_cnt_a", cnt_a, 1);

        // Back-to-back requests capture every other cycle
        snap_req = 1'b1;
        step();
        check("b2b_valid_1", snap_valid, 1);
        check("b2b_snap_a", snap_a, 1);
        check("b2b_snap_b", snap_b, 3);
        step();
        check("b2b_valid_0", snap_valid, 0);
        step();
        check("b2b_valid_2", snap_valid, 1);
        check("b2b_snap_a_2", snap_a, 0);
        snap_req = 1'b0;
        step();
        check("b2b_done", snap_valid, 0);
        snap_ready = 1'b0;

        // Ready in IDLE has no effect
        snap_ready = 1'b1; step(); snap_ready = 1'b0;
        check("idle_ready", snap_valid, 0);

        // Flags, then clr beats an increment
        y = 2'b01; repeat (4) step();
        check("alarm_again", alarm, 1);
        y = 2'b10; step();
        check("illegal_set", illegal, 1);
        clr = 1'b1; y = 2'b11;
        step();
        clr = 1'b0; y = 2'b00;
        check("clr_cnt_b", cnt_b, 0);
        check("clr_cnt_a", cnt_a, 0);
        check("clr_flags", {ovf, alarm, illegal}, 0);

        // clr together with snapshot captures pre-clear values
        y = 2'b01; repeat (2) step();
        clr = 1'b1; snap_req = 1'b1;
        step();
        clr = 1'b0; snap_req = 1'b0; y = 2'b00;
        check("clrsnap_valid", snap_valid, 1);
        check("clrsnap_snap_a", snap_a, 2);
        check("clrsnap_cnt_a", cnt_a, 0);

        // Reset during HOLD drops the snapshot
        rst = 1'b0;
        step();
        check("midrst_valid", snap_valid, 0);
        check("midrst_snap_a", snap_a, 0);
        rst = 1'b1;
        step();
        check("midrst_idle", snap_valid, 0);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        check("midrst_req_taken", snap_valid, 1);
        snap_ready = 1'b1;
        step();
        snap_ready = 1'b0;
        check("midrst_accept", snap_valid, 0);

        // Overflow on the 4-bit instance
        clr = 1'b1; step(); clr = 1'b0;
        y = 2'b01;
        repeat (17) step();
        y = 2'b00;
`ifdef DETECT_CNT_SATURATE_EN
        check("ovf4_cnt_a", cnt_a4, 15);
`else
        check("ovf4_cnt_a", cnt_a4, 1);
`endif
        check("ovf4_flag", ovf4, 1);
        check("ovf8_cnt_a", cnt_a, 17);
        check("ovf8_flag", ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/detect_event_counter.md
# detect_event_counter

Downstream consumer of the serial pattern detector's 2-bit code output `y`. Each clock it samples `y`, counts pattern-A events (`y == 2'b01`) and pattern-B events (`y == 2'b11`) in two live counters, and flags codes the detector must never produce. A valid/ready snapshot port hands a coherent pair of counts to the host or test controller, with optional clear-on-read so no event is lost between reads.

## Interface
- `CNT_W`, 8: width of each event counter and snapshot field.
- `A_THRESH`, 4: pattern-A count at which `alarm` sets; range 1 .. 2^CNT_W-1.
- `CLR_ON_SNAP`, 1: 1 = live counters restart on each snapshot; 0 = they keep running.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset; sampled on `clk` rising edge.
- `en` input 1: when 0, `y` is ignored (no counting, no illegal check).
- `y` input 2: detector code: 00 none, 01 pattern A, 11 pattern B, 10 illegal.
- `clr` input 1: synchronous clear of live counters, `ovf`, `alarm` and `illegal`.
- `snap_req` input 1: request a snapshot; level-sampled, honoured only in IDLE.
- `snap_ready` input 1: consumer accepts the snapshot.
- `snap_valid` output 1: snapshot registers hold a pending result.
- `snap_a` output CNT_W: pattern-A count captured at the snapshot.
- `snap_b` output CNT_W: pattern-B count captured at the snapshot.
- `cnt_a`, `cnt_b` output CNT_W: live counters.
- `ovf` output 1: sticky; a counter was incremented while at 2^CNT_W-1.
- `alarm` output 1: sticky; `cnt_a` reached `A_THRESH`.
- `illegal` output 1: sticky; `y == 2'b10` was sampled with `en = 1`.

## Operation
- Reset (`rst = 0` at an edge) forces every output to 0, including `snap_a`, `snap_b`, `cnt_a` and `cnt_b`, and puts the FSM in IDLE. This applies in any state, so a snapshot pending in HOLD is dropped.
- Counting: on an edge with `en = 1`:
  - `y = 01` increments `cnt_a`.
  - `y = 11` increments `cnt_b`.
  - `y = 10` sets `illegal`.
  - `y = 00` does nothing.
- Increments are CNT_W-bit unsigned; overflow behaviour is set by the macro under Configuration.
- `alarm` sets on the edge where `cnt_a` becomes >= `A_THRESH`. It stays set until `clr` or reset.
- `clr` has priority over an increment in the same cycle. Counters go to 0, the event in that cycle is dropped, and the sticky flags clear. `clr` does not affect the snapshot FSM, `snap_a` or `snap_b`.
- Snapshot FSM, two states:
  - IDLE: `snap_valid = 0`. On `snap_req = 1`, load `snap_a`/`snap_b` with the pre-edge `cnt_a`/`cnt_b` and go to HOLD.
  - HOLD: `snap_valid = 1`, and `snap_a`/`snap_b` are held stable. On `snap_valid && snap_ready`, return to IDLE. `snap_req` in HOLD is ignored; requests are not queued.
- Clear-on-snap (`CLR_ON_SNAP = 1`): on the capture edge each live counter restarts at the value of that cycle's event only (1 if an event occurred, else 0). An event coincident with the capture therefore goes into the new count and is never lost or double-counted.
- With `CLR_ON_SNAP = 1`, `clr` and `snap_req` in the same cycle: the snapshot captures the pre-clear values and the counters go to 0.

## Timing
- `y` to `cnt_*`: 1 cycle. The count is visible the cycle after the sampled edge.
- `snap_req` to `snap_valid`: 1 cycle.
- `snap_ready` to `snap_valid` deassert: 1 cycle after the accepting edge.
- Back-to-back snapshots: with `snap_req` held high, a new capture occurs every 2 cycles, because the FSM spends at least one cycle in IDLE after each accept.
- `snap_ready` while in IDLE has no effect.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `DETECT_CNT_SATURATE_EN`.
- Defined: `cnt_a` and `cnt_b` stick at 2^CNT_W-1. Any further increment sets `ovf` and leaves the count unchanged.
- Undefined: counters wrap from 2^CNT_W-1 to 0, and `ovf` sets on the wrapping edge.
- In both builds `ovf` is sticky until `clr` or reset.

## Test plan
- Reset: hold `rst = 0` for 2 cycles while driving `y = 01` -> every output is 0. Release with `y = 00` -> counters stay 0 and `snap_valid = 0`.
- Counting and alarm (`A_THRESH = 4`): drive 5 cycles of `y = 01` and 3 cycles of `y = 11` with `en = 1` -> `cnt_a = 5`, `cnt_b = 3`; `alarm` sets on the edge `cnt_a` becomes 4. Repeat with `en = 0` -> counts unchanged.
- Snapshot handshake (`CLR_ON_SNAP = 1`): `cnt_a = 5`, `cnt_b = 3`, pulse `snap_req` with `y = 01` in the same cycle -> next cycle `snap_valid = 1`, `snap_a = 5`, `snap_b = 3`, `cnt_a = 1`, `cnt_b = 0`. Hold `snap_ready = 0` for 3 cycles -> outputs stable. Assert `snap_ready` -> `snap_valid = 0` the next cycle.
- Priority: `clr = 1` together with `y = 11` -> `cnt_b = 0`, and `alarm`, `ovf`, `illegal` all 0. A second `snap_req` during HOLD is ignored.
- Overflow (`CNT_W = 4`): 17 cycles of `y = 01`. With `DETECT_CNT_SATURATE_EN` -> `cnt_a = 15` and `ovf = 1`. Without it -> `cnt_a = 1` and `ovf = 1`.
- Illegal code and mid-HOLD reset: `y = 10` -> `illegal = 1`. Then snapshot, then `rst = 0` during HOLD -> `snap_valid = 0` and the FSM is in IDLE the next cycle.
